// File: rtl/rca_issue_responder.sv
// rca_issue_responder
//   RCA-side endpoint of the core-to-RCA issue/writeback protocol. Issued ops (id + operands)
//   are buffered in a small FIFO; one op at a time is launched into the grid, its result is
//   captured after a fixed latency and presented to writeback until acknowledged.
//
// Optional feature (macro RCA_ISSUE_ACK_CHAIN_EN):
//   defined     : an ack in WB with a non-empty queue launches the next op in the same cycle
//                 (WB -> EXEC directly).
//   not defined : WB -> IDLE on ack; the next launch happens one cycle later.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   new_request        issue strobe, accepted only while ready=1
//   issue_id, rs_data  id and operands of the issued op (rs1 in [31:0])
//   ready              queue not full
//   grid_start         one-cycle launch pulse
//   grid_operands      operands of the op in flight
//   grid_result        grid outputs, sampled on the last EXEC cycle
//   done, id, rd       writeback valid / id / result words
//   ack                writeback accepted
//   rca_config_locked  queue non-empty or FSM busy
//   rca_lsu_lock       FSM in EXEC
module rca_issue_responder #(
    parameter int unsigned NUM_READ_PORTS  = 5,
    parameter int unsigned NUM_WRITE_PORTS = 2,
    parameter int unsigned ID_W            = 3,
    parameter int unsigned GRID_LATENCY    = 4,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            new_request,
    input  logic [ID_W-1:0]                 issue_id,
    input  logic [NUM_READ_PORTS*32-1:0]    rs_data,
    output logic                            ready,
    output logic                            grid_start,
    output logic [NUM_READ_PORTS*32-1:0]    grid_operands,
    input  logic [NUM_WRITE_PORTS*32-1:0]   grid_result,
    output logic                            done,
    output logic [ID_W-1:0]                 id,
    output logic [NUM_WRITE_PORTS*32-1:0]   rd,
    input  logic                            ack,
    output logic                            rca_config_locked,
    output logic                            rca_lsu_lock
);

    localparam int unsigned OpW   = NUM_READ_PORTS * 32;
    localparam int unsigned ResW  = NUM_WRITE_PORTS * 32;
    localparam int unsigned PtrW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntQW = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned LatW  = 4;

    typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

    state_e state_q, state_d;

    // Issue queue
    logic [ID_W-1:0]  q_id_mem   [QUEUE_DEPTH];
    logic [OpW-1:0]   q_data_mem [QUEUE_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntQW-1:0] count_q, count_d;
    logic             q_empty;
    logic             push;

    // Op in flight / writeback
    logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [OpW-1:0]   operands_q, operands_d;
    logic [ID_W-1:0]  op_id_q, op_id_d;
    logic [ResW-1:0]  rd_q, rd_d;

    assign q_empty = (count_q == '0);
    assign ready   = (count_q != CntQW'(QUEUE_DEPTH));
    // Full check ignores a same-cycle pop; strobes while not ready are dropped.
    assign push    = new_request && ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lat_cnt_q  <= '0;
            operands_q <= '0;
            op_id_q    <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lat_cnt_q  <= lat_cnt_d;
            operands_q <= operands_d;
            op_id_q    <= op_id_d;
            rd_q       <= rd_d;
        end
    end

    // Queue storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_id_mem[wr_ptr_q]   <= issue_id;
            q_data_mem[wr_ptr_q] <= rs_data;
        end
    end

    // Next-state logic; grid_start doubles as the queue pop.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        operands_d = operands_q;
        op_id_d    = op_id_q;
        rd_d       = rd_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        unique case (state_q)
            StIdle: begin
                if (!q_empty) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (lat_cnt_q == '0) begin
                    rd_d    = grid_result;
                    state_d = StWb;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            StWb: begin
                if (ack) begin
`ifdef RCA_ISSUE_ACK_CHAIN_EN
                    state_d = q_empty ? StIdle : StExec;
`else
                    state_d = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (grid_start) begin
            operands_d = q_data_mem[rd_ptr_q];
            op_id_d    = q_id_mem[rd_ptr_q];
            lat_cnt_d  = LatW'(GRID_LATENCY - 1);
            rd_ptr_d   = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end

        unique case ({push, grid_start})
            2'b10:   count_d = count_q + CntQW'(1);
            2'b01:   count_d = count_q - CntQW'(1);
            default: count_d = count_q;
        endcase
    end

    // Outputs
    always_comb begin
        grid_start = 1'b0;
        unique case (state_q)
            StIdle: grid_start = !q_empty;
`ifdef RCA_ISSUE_ACK_CHAIN_EN
            StWb:   grid_start = ack && !q_empty;
`endif
            default: grid_start = 1'b0;
        endcase
    end

    assign done              = (state_q == StWb);
    assign id                = op_id_q;
    assign rd                = rd_q;
    assign grid_operands     = operands_q;
    assign rca_config_locked = !q_empty || (state_q != StIdle);
    assign rca_lsu_lock      = (state_q == StExec);

endmodule

// File: tb/tb_rca_issue_responder.sv
module tb_rca_issue_responder;

    localparam int unsigned NRP = 5;
    localparam int unsigned NWP = 2;
    localparam int unsigned IDW = 3;
    localparam int unsigned LAT = 4;
    localparam int unsigned QD  = 2;
`ifdef RCA_ISSUE_ACK_CHAIN_EN
    localparam int SPACING = LAT + 1;
`else
    localparam int SPACING = LAT + 2;
`endif
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_CAFE_F00D;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            new_request;
    logic [IDW-1:0]  issue_id;
    logic [NRP*32-1:0] rs_data;
    logic            ready;
    logic            grid_start;
    logic [NRP*32-1:0] grid_operands;
    logic [NWP*32-1:0] grid_result;
    logic            done;
    logic [IDW-1:0]  id;
    logic [NWP*32-1:0] rd;
    logic            ack;
    logic            rca_config_locked;
    logic            rca_lsu_lock;

    // Result source: either a directed value or a function of the operands in flight.
    logic            gr_mode;
    logic [63:0]     gr_drive;
    assign grid_result = gr_mode ? {~grid_operands[31:0], grid_operands[31:0]} : gr_drive;

    always #5 clk = ~clk;

    rca_issue_responder #(
        .NUM_READ_PORTS (NRP),
        .NUM_WRITE_PORTS(NWP),
        .ID_W           (IDW),
        .GRID_LATENCY   (LAT),
        .QUEUE_DEPTH    (QD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .new_request      (new_request),
        .issue_id         (issue_id),
        .rs_data          (rs_data),
        .ready            (ready),
        .grid_start       (grid_start),
        .grid_operands    (grid_operands),
        .grid_result      (grid_result),
        .done             (done),
        .id               (id),
        .rd               (rd),
        .ack              (ack),
        .rca_config_locked(rca_config_locked),
        .rca_lsu_lock     (rca_lsu_lock)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [IDW-1:0] i, input logic [NRP*32-1:0] d);
        new_request = 1'b1;
        issue_id    = i;
        rs_data     = d;
        step();
        new_request = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk(name, done, 1'b1);
    endtask

    typedef struct {
        logic [IDW-1:0]    in_id;
        logic [NRP*32-1:0] in_rs;
        logic [63:0]       in_res;
        logic [IDW-1:0]    exp_id;
        logic [63:0]       exp_rd;
    } vec_t;

    vec_t vecs[4];
    int   got_id[$];
    logic [63:0] got_rd[$];
    int   starts[$];

    initial begin
        vecs[0] = '{3'd3, 160'h10, {32'h2, 32'h1}, 3'd3, {32'h2, 32'h1}};
        vecs[1] = '{3'd7, {160{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{3'd0, {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, 64'h0, 3'd0, 64'h0};
        vecs[3] = '{3'd5, {5{32'hA5A5_5A5A}}, 64'h1234_5678_9ABC_DEF0, 3'd5,
                    64'h1234_5678_9ABC_DEF0};

        rst_n = 1'b0; new_request = 1'b0; issue_id = '0; rs_data = '0; ack = 1'b0;
        gr_mode = 1'b0; gr_drive = GARBAGE;
        step(); step();
        chk("rst_ready", ready, 1'b1);
        chk("rst_start", grid_start, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_id", id, 0);
        chk("rst_rd", rd, 0);
        chk("rst_operands", grid_operands, 0);
        chk("rst_cfg_lock", rca_config_locked, 1'b0);
        chk("rst_lsu_lock", rca_lsu_lock, 1'b0);
        rst_n = 1'b1;
        step();

        // Single-op vectors with exact latency: accept T, start T+1, sample T+1+L, done T+2+L
        for (int v = 0; v < 4; v++) begin
            issue(vecs[v].in_id, vecs[v].in_rs);           // now T+1
            chk("vec_start", grid_start, 1'b1);
            chk("vec_cfg_lock", rca_config_locked, 1'b1);
            step();                                         // T+2
            chk("vec_start_pulse", grid_start, 1'b0);
            chk("vec_operands", grid_operands, vecs[v].in_rs);
            chk("vec_lsu_lock", rca_lsu_lock, 1'b1);
            repeat (LAT - 1) step();                        // T+1+L
            chk("vec_no_early_done", done, 1'b0);
            chk("vec_operands_stable", grid_operands, vecs[v].in_rs);
            gr_drive = vecs[v].in_res;
            step();                                         // T+2+L
            gr_drive = GARBAGE;
            chk("vec_done", done, 1'b1);
            chk("vec_id", id, vecs[v].exp_id);
            chk("vec_rd", rd, vecs[v].exp_rd);
            chk("vec_lsu_off", rca_lsu_lock, 1'b0);
            ack = 1'b1;
            step();
            ack = 1'b0;
            chk("vec_done_clr", done, 1'b0);
            chk("vec_cfg_unlock", rca_config_locked, 1'b0);
        end

        // Hold in WB with ack low
        gr_drive = 64'h0123_4567_89AB_CDEF;
        issue(3'd2, 160'h55);
        wait_done("hold_reach_wb");
        for (int c = 0; c < 10; c++) begin
            chk("hold_done", done, 1'b1);
            chk("hold_id", id, 3'd2);
            chk("hold_rd", rd, 64'h0123_4567_89AB_CDEF);
            chk("hold_start", grid_start, 1'b0);
            chk("hold_cfg_lock", rca_config_locked, 1'b1);
            step();
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        gr_drive = GARBAGE;

        // Backpressure: op 1 parked in WB, then three strobes back-to-back
        issue(3'd1, 160'h1);
        wait_done("bp_reach_wb");
        new_request = 1'b1; issue_id = 3'd2; rs_data = 160'h2;
        chk("bp_ready0", ready, 1'b1);
        step();
        issue_id = 3'd3; rs_data = 160'h3;
        chk("bp_ready1", ready, 1'b1);
        step();
        issue_id = 3'd4; rs_data = 160'h4;
        chk("bp_ready_full", ready, 1'b0);
        step();
        new_request = 1'b0;
        chk("bp_still_full", ready, 1'b0);
        gr_mode = 1'b1;
        ack = 1'b1;
        got_id.delete();
        for (int c = 0; c < 60; c++) begin
            if (done) got_id.push_back(int'(id));
            step();
        end
        ack = 1'b0;
        chk("bp_count", got_id.size(), 3);
        for (int i = 0; i < got_id.size() && i < 3; i++) chk("bp_order", got_id[i], i + 1);
        chk("bp_drained", rca_config_locked, 1'b0);

        // Ordering and launch spacing with ack held high
        got_id.delete(); got_rd.delete(); starts.delete();
        ack = 1'b1;
        for (int c = 0; c < 40; c++) begin
            new_request = (c < 2);
            issue_id    = (c == 0) ? 3'd5 : 3'd6;
            rs_data     = (c == 0) ? 160'h505 : 160'h606;
            if (grid_start) starts.push_back(c);
            if (done) begin
                got_id.push_back(int'(id));
                got_rd.push_back(rd);
            end
            step();
        end
        new_request = 1'b0;
        chk("ord_starts", starts.size(), 2);
        chk("ord_done_count", got_id.size(), 2);
        if (starts.size() == 2) begin
            chk("ord_first_start", starts[0], 1);
            chk("ord_spacing", starts[1] - starts[0], SPACING);
        end
        if (got_id.size() == 2) begin
            chk("ord_id0", got_id[0], 5);
            chk("ord_id1", got_id[1], 6);
            chk("ord_rd0", got_rd[0], {~32'h505, 32'h505});
            chk("ord_rd1", got_rd[1], {~32'h606, 32'h606});
        end

        // Wrap: 8 ops through the depth-2 queue, pushing whenever ready
        begin
            int next = 0;
            got_id.delete(); got_rd.delete();
            for (int c = 0; c < 200 && got_id.size() < 8; c++) begin
                new_request = (next < 8);
                issue_id    = IDW'(next);
                rs_data     = 160'(32'h100 + next);
                if (done) begin
                    got_id.push_back(int'(id));
                    got_rd.push_back(rd);
                end
                if (new_request && ready) next++;
                step();
            end
            new_request = 1'b0;
        end
        chk("wrap_count", got_id.size(), 8);
        for (int i = 0; i < got_id.size(); i++) begin
            chk("wrap_id", got_id[i], i);
            chk("wrap_rd", got_rd[i], {~(32'h100 + 32'(i)), 32'h100 + 32'(i)});
        end
        step();
        ack = 1'b0;
        gr_mode = 1'b0;
        step(); step();

        // Synchronous reset mid-EXEC
        issue(3'd4, 160'h44);                               // T+1
        step();                                             // T+2
        step();                                             // T+3
        chk("rst_mid_in_exec", rca_lsu_lock, 1'b1);
        rst_n = 1'b0;
        step();                                             // T+4
        chk("rstm_done", done, 1'b0);
        chk("rstm_ready", ready, 1'b1);
        chk("rstm_cfg_lock", rca_config_locked, 1'b0);
        chk("rstm_lsu_lock", rca_lsu_lock, 1'b0);
        chk("rstm_operands", grid_operands, 0);
        rst_n = 1'b1;
        begin
            int stale = 0;
            for (int c = 0; c < 15; c++) begin
                if (done || grid_start) stale++;
                step();
            end
            chk("rstm_no_stale", stale, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
